// File: rtl/disc_ctrl.sv
// Disc-side responder: accepts line read requests, models a fixed seek latency,
// then returns one 128-bit line from a preloadable array with a one-cycle strobe.
module disc_ctrl #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_disc,
    input  logic [32:0]           adr_disc,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_line,
    input  logic [127:0]          wr_data,
    output logic [127:0]          data_disc,
    output logic                  finished_disc,
    output logic                  err_disc,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SEEK, DONE, WAIT_LOW} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [28:0] adr_q, adr_nxt;
    logic        load;
    logic        oor;
    logic        unused_low;

    logic [127:0] mem [0:(1 << DEPTH_LOG2) - 1];

    // Low nibble selects a byte within the line and never affects the result.
    assign unused_low = ^adr_disc[3:0];
    assign oor        = |adr_q[28:DEPTH_LOG2];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adr_nxt   = adr_q;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (read_disc) begin
                    state_nxt = SEEK;
                    cnt_nxt   = 8'(LATENCY - 1);
                    adr_nxt   = adr_disc[32:4];
                end
            end
            SEEK: begin
                // A dropped request wins over completion, even on the final count.
                if (!read_disc) begin
                    state_nxt = IDLE;
                end else if (cnt == 8'd0) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DONE: begin
                state_nxt = read_disc ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
                if (!read_disc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            adr_q         <= '0;
            data_disc     <= '0;
            err_disc      <= 1'b0;
            finished_disc <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            adr_q         <= adr_nxt;
            finished_disc <= load;
            busy          <= (state_nxt != IDLE);
            if (load) begin
                data_disc <= oor ? '0 : mem[adr_q[DEPTH_LOG2-1:0]];
                err_disc  <= oor;
            end
        end
    end

    // Contents survive reset; a same-edge write is not seen by the read above.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_line] <= wr_data;
        end
    end

endmodule

// File: tb/tb_disc_ctrl.sv
// Directed bench for disc_ctrl with a scoreboard of expected read results.
module tb_disc_ctrl;

    localparam int unsigned LAT = 8;
    localparam int unsigned DL2 = 6;

    typedef struct packed {
        logic [127:0] d;
        logic         e;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           read_disc;
    logic           read1;
    logic [32:0]    adr_disc;
    logic           wr_en;
    logic [DL2-1:0] wr_line;
    logic [127:0]   wr_data;
    logic [127:0]   data_disc, data1;
    logic           finished_disc, fin1;
    logic           err_disc, err1;
    logic           busy, busy1;

    int   tests   = 0;
    int   failed  = 0;
    int   strobes = 0;
    exp_t sb[$];

    localparam logic [127:0] V1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] VA = {32{4'hA}};
    localparam logic [127:0] V5 = {32{4'h5}};

    disc_ctrl #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .read_disc(read_disc), .adr_disc(adr_disc),
        .wr_en(wr_en), .wr_line(wr_line), .wr_data(wr_data),
        .data_disc(data_disc), .finished_disc(finished_disc),
        .err_disc(err_disc), .busy(busy)
    );

    disc_ctrl #(.LATENCY(1), .DEPTH_LOG2(DL2)) dut1 (
        .clk(clk), .rst(rst), .read_disc(read1), .adr_disc(adr_disc),
        .wr_en(wr_en), .wr_line(wr_line), .wr_data(wr_data),
        .data_disc(data1), .finished_disc(fin1),
        .err_disc(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (finished_disc) strobes++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [DL2-1:0] line, input logic [127:0] d);
        wr_en = 1'b1; wr_line = line; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [32:0] a, input logic [127:0] ed, input logic ee,
                           input int unsigned hold);
        int   n;
        int   s0;
        exp_t e;
        sb.push_back('{d: ed, e: ee});
        s0 = strobes;
        adr_disc = a; read_disc = 1'b1;
        step();
        chk("busy_rise", 128'(busy), 128'(1));
        n = 0;
        while (!finished_disc && n < 40) begin
            step();
            n++;
        end
        chk("latency", 128'(n), 128'(LAT));
        e = sb.pop_front();
        chk("data", data_disc, e.d);
        chk("err", 128'(err_disc), 128'(e.e));
        repeat (hold) step();
        chk("busy_hold", 128'(busy), 128'(1));
        read_disc = 1'b0;
        step();
        chk("one_strobe", 128'(strobes - s0), 128'(1));
        step();
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        int   s0;
        exp_t e;
        rst = 1'b1; read_disc = 1'b0; read1 = 1'b0; adr_disc = '0;
        wr_en = 1'b0; wr_line = '0; wr_data = '0;
        step(); step();
        chk("rst_data", data_disc, '0);
        chk("rst_fin", 128'(finished_disc), 128'(0));
        chk("rst_err", 128'(err_disc), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        step();

        wr(6'd1, V1);
        do_read(33'h10, V1, 1'b0, 0);

        // abort three cycles after acceptance
        s0 = strobes;
        adr_disc = 33'h400; read_disc = 1'b1;
        step();
        repeat (3) step();
        read_disc = 1'b0;
        step();
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (12) step();
        chk("abort_nostrobe", 128'(strobes - s0), 128'(0));
        chk("abort_data", data_disc, V1);
        chk("abort_err", 128'(err_disc), 128'(0));

        do_read(33'h400, '0, 1'b1, 0);

        // write collision: A at edge k+3 visible, 5 at edge k+8 not visible
        sb.push_back('{d: VA, e: 1'b0});
        adr_disc = 33'h20; read_disc = 1'b1;
        step();
        repeat (2) step();
        wr(6'd2, VA);
        repeat (4) step();
        wr_en = 1'b1; wr_line = 6'd2; wr_data = V5;
        step();
        wr_en = 1'b0;
        chk("coll_fin", 128'(finished_disc), 128'(1));
        e = sb.pop_front();
        chk("coll_data", data_disc, e.d);
        read_disc = 1'b0;
        step(); step();
        do_read(33'h20, V5, 1'b0, 0);

        do_read(33'h10, V1, 1'b0, 20);

        // reset at cycle 4 of SEEK
        s0 = strobes;
        adr_disc = 33'h20; read_disc = 1'b1;
        step();
        repeat (3) step();
        rst = 1'b1; read_disc = 1'b0;
        step();
        rst = 1'b0;
        chk("mrst_data", data_disc, '0);
        chk("mrst_err", 128'(err_disc), 128'(0));
        chk("mrst_busy", 128'(busy), 128'(0));
        repeat (12) step();
        chk("mrst_nostrobe", 128'(strobes - s0), 128'(0));
        do_read(33'h10, V1, 1'b0, 0);

        // LATENCY=1 instance: done one edge after acceptance
        sb.push_back('{d: V1, e: 1'b0});
        adr_disc = 33'h10; read1 = 1'b1;
        step();
        chk("l1_fin_early", 128'(fin1), 128'(0));
        step();
        chk("l1_fin", 128'(fin1), 128'(1));
        e = sb.pop_front();
        chk("l1_data", data1, e.d);
        read1 = 1'b0;
        step(); step();
        chk("l1_busy", 128'(busy1), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
